// File: rtl/p405s_exectrreg_if.sv
// EXE/WB-side view of the Count Register block: update requests in, CTR state and back-pressure out.
// The pipeline side uses master, the CTR block uses slave.
interface p405s_exectrreg_if #(
    parameter int CTR_W = 32
);
    logic             exeBrValid;
    logic [0:3]       exeBOL2;
    logic             exeCtrTgt;
    logic             exeMtCtrValid;
    logic [0:CTR_W-1] exeMtCtrData;
    logic             wbCommit;
    logic             wbFlush;
    logic             exeCtrEq0;
    logic [0:CTR_W-1] ctrL2;
    logic [0:CTR_W-1] ctrArchL2;
    logic             exeCtrBusy;

    modport master (
        output exeBrValid, exeBOL2, exeCtrTgt, exeMtCtrValid, exeMtCtrData, wbCommit, wbFlush,
        input  exeCtrEq0, ctrL2, ctrArchL2, exeCtrBusy
    );

    modport slave (
        input  exeBrValid, exeBOL2, exeCtrTgt, exeMtCtrValid, exeMtCtrData, wbCommit, wbFlush,
        output exeCtrEq0, ctrL2, ctrArchL2, exeCtrBusy
    );
endinterface

// File: rtl/p405s_exectrreg.sv
// Speculative + architected Count Register with a one-entry pending-commit buffer.
// Latency: ctrL2 1 cycle after update/flush, ctrArchL2 1 cycle after wbCommit; exeCtrEq0 combinational.
// Backpressure: exeCtrBusy while an update is pending and WB neither commits nor flushes this cycle.
module p405s_exectrreg #(
    parameter int CTR_W = 32
) (
    input  logic                  CB,
    input  logic                  resetCore_Neg,
    p405s_exectrreg_if.slave      bus
);
    typedef enum logic {IDLE = 1'b0, PEND = 1'b1} pendState_t;

    localparam logic [0:CTR_W-1] ONE = {{(CTR_W-1){1'b0}}, 1'b1};

    pendState_t       state, stateNxt;
    logic [0:CTR_W-1] ctrQ, ctrNxt;
    logic [0:CTR_W-1] archQ, archNxt;
    logic [0:CTR_W-1] pendData, pendNxt;

    logic             decEn;
    logic             wrEn;
    logic             upd;
    logic [0:CTR_W-1] newVal;

    // bcctr never decrements: CTR is the target, so BO[2]=0 there is an invalid form
    assign decEn  = bus.exeBrValid & ~bus.exeBOL2[2] & ~bus.exeCtrTgt;
    assign wrEn   = bus.exeMtCtrValid;
    assign upd    = (decEn | wrEn) & ~bus.wbFlush;
    assign newVal = wrEn ? bus.exeMtCtrData : (ctrQ - ONE);

    always_comb begin
        stateNxt = state;
        ctrNxt   = ctrQ;
        archNxt  = archQ;
        pendNxt  = pendData;
        case (state)
            IDLE: begin
                if (bus.wbFlush) begin
                    ctrNxt = archQ;
                end else if (upd) begin
                    ctrNxt   = newVal;
                    pendNxt  = newVal;
                    stateNxt = PEND;
                end
            end
            PEND: begin
                if (bus.wbCommit) begin
                    archNxt = pendData;
                end
                if (bus.wbFlush) begin
                    // a commit in the same cycle retires first, so restore from the retiring value
                    ctrNxt   = bus.wbCommit ? pendData : archQ;
                    stateNxt = IDLE;
                end else if (bus.wbCommit) begin
                    if (upd) begin
                        ctrNxt  = newVal;
                        pendNxt = newVal;
                    end else begin
                        stateNxt = IDLE;
                    end
                end
            end
            default: stateNxt = IDLE;
        endcase
    end

    always_ff @(posedge CB) begin
        if (!resetCore_Neg) begin
            state    <= IDLE;
            ctrQ     <= '0;
            archQ    <= '0;
            pendData <= '0;
        end else begin
            state    <= stateNxt;
            ctrQ     <= ctrNxt;
            archQ    <= archNxt;
            pendData <= pendNxt;
        end
    end

    assign bus.ctrL2      = ctrQ;
    assign bus.ctrArchL2  = archQ;
    assign bus.exeCtrEq0  = (ctrQ == ONE);
    assign bus.exeCtrBusy = (state == PEND) & ~bus.wbCommit & ~bus.wbFlush;
endmodule

// File: doc/p405s_exectrreg.md
Name: p405s_exeCtrReg

Overview:
- Owns the Count Register (CTR) for the execute stage.
- Updates CTR speculatively in EXE on CTR-decrementing branches and mtctr, and keeps a committed architectural copy.
- Supplies exeCtrEq0 to the branch-condition evaluation logic in the same EXE cycle.
- Restores the speculative CTR on a writeback flush, and provides a one-entry pending buffer with back-pressure.

Parameters:
- CTR_W, 32, CTR width in bits (big-endian numbering [0:CTR_W-1]).

Ports:
- CB  input  1  core clock; all state updates on the rising edge.
- resetCore_Neg  input  1  synchronous active-low reset.
- exeBrValid  input  1  branch in EXE is valid and advances this cycle.
- exeBOL2  input  [0:3]  BO field bits 0..3 of the EXE branch.
- exeCtrTgt  input  1  EXE branch is bcctr (CTR used as target).
- exeMtCtrValid  input  1  mtctr in EXE is valid and advances this cycle.
- exeMtCtrData  input  [0:31]  mtctr source data.
- wbCommit  input  1  oldest pending CTR update retires this cycle.
- wbFlush  input  1  pipeline flush from WB; discard speculative CTR state.
- exeCtrEq0  output  1  decremented CTR equals zero, i.e. ctrL2 == 1.
- ctrL2  output  [0:31]  speculative CTR (branch target source for bcctr).
- ctrArchL2  output  [0:31]  architected (committed) CTR.
- exeCtrBusy  output  1  back-pressure: EXE must not issue a CTR update.

Behaviour:
- Reset (resetCore_Neg=0 at an edge):
  - ctrL2=0, ctrArchL2=0, pendValid=0, pendData=0.
  - Resulting outputs: exeCtrEq0=0, exeCtrBusy=0.
  - Reset overrides every other input.
- decEn = exeBrValid & ~exeBOL2[2] & ~exeCtrTgt.
  - bcctr with BO[2]=0 is an invalid form: no decrement; exeCtrEq0 is still driven.
- wrEn = exeMtCtrValid.
  - If wrEn and decEn are both set (illegal), mtctr wins.
- upd = (decEn | wrEn) & ~wbFlush.
  - newVal = wrEn ? exeMtCtrData : ctrL2 - 1, modulo 2^32.
  - 0 decrements to 0xFFFFFFFF, with no sticky flag.
- exeCtrEq0 is purely combinational from the registered ctrL2: (ctrL2 == 32'h00000001).
  - There is no bypass from a same-cycle mtctr; the issue logic guarantees that separation.
- Pending buffer is a two-state FSM with pendValid as the state bit.
  - IDLE (pendValid=0):
    - upd → ctrL2<=newVal, pendData<=newVal, go to PEND.
    - wbCommit is ignored.
  - PEND (pendValid=1):
    - wbFlush → ctrL2<=ctrArchL2 (or pendData when wbCommit is also set), go to IDLE.
    - wbCommit & ~wbFlush → ctrArchL2<=pendData.
      - If upd is also set: ctrL2<=newVal, pendData<=newVal, stay in PEND (back-to-back).
      - Otherwise go to IDLE.
    - wbCommit & wbFlush: commit applies first (ctrArchL2<=pendData), then ctrL2<=pendData, go to IDLE.
    - Neither commit nor flush: hold state.
      - Any upd in this case is a protocol violation and is ignored; ctrL2 is unchanged.
- exeCtrBusy = pendValid & ~wbCommit & ~wbFlush, combinational.
- Latency:
  - ctrL2 changes 1 cycle after upd.
  - ctrArchL2 changes 1 cycle after wbCommit.
  - Flush restore takes 1 cycle.
- wbFlush in IDLE: ctrL2<=ctrArchL2, which is a no-op when already equal.
- Reset mid-PEND drops the pending update; no commit occurs.

Test Plan:
- Reset, then mtctr data=5 and wbCommit next cycle → ctrL2=5, ctrArchL2=5, exeCtrEq0=0, exeCtrBusy=0 after commit.
- ctrL2=1, bc with BO=4'b0000 → exeCtrEq0=1 that cycle; next cycle ctrL2=0, pendValid=1, exeCtrBusy=1.
- ctrL2=0, decrement → ctrL2=0xFFFFFFFF, exeCtrEq0=0; commit → ctrArchL2=0xFFFFFFFF.
- ctrArchL2=7, decrement to 6, then wbFlush without commit → ctrL2=7 next cycle, pendValid=0.
- PEND holding value 4, with wbCommit plus a new decrement in the same cycle → ctrArchL2=4, ctrL2=3, pendValid stays 1.
- bcctr with BO[2]=0 and ctrL2=9 → no decrement, ctrL2=9, pendValid=0.
- mtctr and decrement asserted together → mtctr data wins.
- resetCore_Neg low during PEND → all registers 0 next cycle.
